// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU for the MIPS core's execute stage.
//   Single-cycle ops (add/sub, shifts, logic, set-less-than) finish one cycle
//   after acceptance. MULU (shift-add) and DIVU (restoring) iterate one bit per
//   cycle and finish WIDTH+1 cycles after acceptance.
//
// Configuration macro: SEQ_ALU_DIV_EN
//   defined   -> divider datapath present, DIVU supported.
//   undefined -> no divider logic, DIVU is reported as an illegal op.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   valid_alu_i/ready_alu_o request handshake; opr_a_alu_i, opr_b_alu_i, op_alu_i
//   valid_alu_o/ready_alu_i result handshake; res_alu_o, hi_alu_o,
//                           z_alu_o, n_alu_o, ill_alu_o
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds valid and its payload stable until that edge; ready
// may depend combinationally on the other side's ready (ready_alu_o follows
// ready_alu_i while a result is pending) but never on the same side's valid.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_alu_i,
  output logic             ready_alu_o,
  input  logic [WIDTH-1:0] opr_a_alu_i,
  input  logic [WIDTH-1:0] opr_b_alu_i,
  input  logic [3:0]       op_alu_i,
  output logic             valid_alu_o,
  input  logic             ready_alu_i,
  output logic [WIDTH-1:0] res_alu_o,
  output logic [WIDTH-1:0] hi_alu_o,
  output logic             z_alu_o,
  output logic             n_alu_o,
  output logic             ill_alu_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SHL  = 4'd2;
  localparam logic [3:0] OP_LSR  = 4'd3;
  localparam logic [3:0] OP_ASR  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MULU = 4'd11;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd12;
`endif

  // WIDTH iteration edges (counter 0..WIDTH-1) plus one edge that moves the
  // working registers to the outputs, giving WIDTH+1 cycles of latency.
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_w_q, hi_w_d;   // partial product high half / remainder
  logic [WIDTH-1:0] lo_w_q, lo_w_d;   // multiplier / dividend-quotient shifter
  logic [WIDTH-1:0] b_w_q, b_w_d;     // multiplicand / divisor
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             ill_q, ill_d;
`ifdef SEQ_ALU_DIV_EN
  logic             is_div_q, is_div_d;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
`endif

  logic             accept;
  logic             is_iter;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ill;
  logic             slt_s, slt_u;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   mul_sum;

  assign valid_alu_o = (state_q == ST_DONE);
  assign ready_alu_o = (state_q == ST_IDLE) || ((state_q == ST_DONE) && ready_alu_i);
  assign accept      = valid_alu_i && ready_alu_o;
  assign res_alu_o   = res_q;
  assign hi_alu_o    = hi_q;
  assign ill_alu_o   = ill_q;
  assign z_alu_o     = (res_q == '0);
  assign n_alu_o     = res_q[WIDTH-1];

  // Single-cycle datapath, evaluated on the request operands.
  always_comb begin
    shamt  = opr_b_alu_i[SHW-1:0];
    slt_s  = $signed(opr_a_alu_i) < $signed(opr_b_alu_i);
    slt_u  = opr_a_alu_i < opr_b_alu_i;
    sc_res = '0;
    sc_ill = 1'b0;
    case (op_alu_i)
      OP_ADD:  sc_res = opr_a_alu_i + opr_b_alu_i;
      OP_SUB:  sc_res = opr_a_alu_i - opr_b_alu_i;
      OP_SHL:  sc_res = opr_a_alu_i << shamt;
      OP_LSR:  sc_res = opr_a_alu_i >> shamt;
      OP_ASR:  sc_res = $unsigned($signed(opr_a_alu_i) >>> shamt);
      OP_OR:   sc_res = opr_a_alu_i | opr_b_alu_i;
      OP_AND:  sc_res = opr_a_alu_i & opr_b_alu_i;
      OP_NOR:  sc_res = ~(opr_a_alu_i | opr_b_alu_i);
      OP_XOR:  sc_res = opr_a_alu_i ^ opr_b_alu_i;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, slt_s};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, slt_u};
      default: sc_ill = 1'b1;   // also DIVU when the divider is absent
    endcase
  end

`ifdef SEQ_ALU_DIV_EN
  assign is_iter = (op_alu_i == OP_MULU) || (op_alu_i == OP_DIVU);
  // Restoring step: shift in the next dividend bit, subtract if it fits.
  // A zero divisor always "fits", yielding all-ones quotient, remainder = dividend.
  assign div_sh  = {hi_w_q, lo_w_q[WIDTH-1]};
  assign div_ge  = (div_sh >= {1'b0, b_w_q});
`else
  assign is_iter = (op_alu_i == OP_MULU);
`endif

  // Shift-add step: add multiplicand to the high half when the current
  // multiplier bit is set, then shift {carry, hi, lo} right by one.
  assign mul_sum = {1'b0, hi_w_q} + (lo_w_q[0] ? {1'b0, b_w_q} : '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_w_d  = hi_w_q;
    lo_w_d  = lo_w_q;
    b_w_d   = b_w_q;
    res_d   = res_q;
    hi_d    = hi_q;
    ill_d   = ill_q;
`ifdef SEQ_ALU_DIV_EN
    is_div_d = is_div_q;
`endif
    case (state_q)
      ST_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          res_d   = lo_w_q;
          hi_d    = hi_w_q;
          ill_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
`ifdef SEQ_ALU_DIV_EN
          if (is_div_q) begin
            // When div_ge holds the difference is below the divisor, so the
            // low WIDTH bits of the subtraction are exact.
            hi_w_d = div_ge ? (div_sh[WIDTH-1:0] - b_w_q) : div_sh[WIDTH-1:0];
            lo_w_d = {lo_w_q[WIDTH-2:0], div_ge};
          end else begin
            hi_w_d = mul_sum[WIDTH:1];
            lo_w_d = {mul_sum[0], lo_w_q[WIDTH-1:1]};
          end
`else
          hi_w_d = mul_sum[WIDTH:1];
          lo_w_d = {mul_sum[0], lo_w_q[WIDTH-1:1]};
`endif
        end
      end
      default: begin  // ST_IDLE, ST_DONE
        if ((state_q == ST_DONE) && ready_alu_i) state_d = ST_IDLE;
        if (accept) begin
          if (is_iter) begin
            state_d = ST_BUSY;
            cnt_d   = '0;
            hi_w_d  = '0;
            lo_w_d  = opr_a_alu_i;
            b_w_d   = opr_b_alu_i;
`ifdef SEQ_ALU_DIV_EN
            is_div_d = (op_alu_i == OP_DIVU);
`endif
          end else begin
            state_d = ST_DONE;
            res_d   = sc_res;
            hi_d    = '0;
            ill_d   = sc_ill;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_w_q  <= '0;
      lo_w_q  <= '0;
      b_w_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      ill_q   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_w_q  <= hi_w_d;
      lo_w_q  <= lo_w_d;
      b_w_q   <= b_w_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      ill_q   <= ill_d;
`ifdef SEQ_ALU_DIV_EN
      is_div_q <= is_div_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed testbench for seq_alu at WIDTH=32.
//   Driver tasks issue requests and push the hand-computed response onto
//   exp_q; a monitor on the falling edge pops and compares every result that
//   is handed over (valid_alu_o && ready_alu_i).
module tb_seq_alu;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         valid_alu_i;
  logic         ready_alu_o;
  logic [W-1:0] opr_a_alu_i;
  logic [W-1:0] opr_b_alu_i;
  logic [3:0]   op_alu_i;
  logic         valid_alu_o;
  logic         ready_alu_i;
  logic [W-1:0] res_alu_o;
  logic [W-1:0] hi_alu_o;
  logic         z_alu_o;
  logic         n_alu_o;
  logic         ill_alu_o;

  // {ill, hi, res}
  logic [2*W:0] exp_q[$];
  int n_checks;
  int n_fail;

  seq_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_alu_i (valid_alu_i),
    .ready_alu_o (ready_alu_o),
    .opr_a_alu_i (opr_a_alu_i),
    .opr_b_alu_i (opr_b_alu_i),
    .op_alu_i    (op_alu_i),
    .valid_alu_o (valid_alu_o),
    .ready_alu_i (ready_alu_i),
    .res_alu_o   (res_alu_o),
    .hi_alu_o    (hi_alu_o),
    .z_alu_o     (z_alu_o),
    .n_alu_o     (n_alu_o),
    .ill_alu_o   (ill_alu_o)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and holds it until accepted; the expected response is
  // queued right before the accepting edge. Returns cycles spent waiting.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] e_res, input logic [W-1:0] e_hi,
                       input logic e_ill, output int waits);
    bit done;
    done  = 0;
    waits = 0;
    valid_alu_i = 1'b1;
    op_alu_i    = op;
    opr_a_alu_i = a;
    opr_b_alu_i = b;
    while (!done && waits < 100) begin
      if (ready_alu_o === 1'b1) begin
        exp_q.push_back({e_ill, e_hi, e_res});
        done = 1;
      end else begin
        waits++;
      end
      step();
    end
    valid_alu_i = 1'b0;
    if (!done) check("issue_timeout", 64'(waits), 64'd0);
  endtask

  // Counts edges from the acceptance edge until valid_alu_o rises, checking
  // ready_alu_o stays low while the block iterates.
  task automatic wait_result(output int lat, output bit ready_seen);
    lat = 0;
    ready_seen = 0;
    while (valid_alu_o !== 1'b1 && lat < 200) begin
      if (ready_alu_o !== 1'b0) ready_seen = 1;
      step();
      lat++;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [2*W:0] e;
    if (rst_n === 1'b1 && valid_alu_o === 1'b1 && ready_alu_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: res=0x%0h hi=0x%0h with no request pending", res_alu_o, hi_alu_o);
      end else begin
        e = exp_q.pop_front();
        check("res", 64'(res_alu_o), 64'(e[W-1:0]));
        check("hi",  64'(hi_alu_o),  64'(e[2*W-1:W]));
        check("ill", 64'(ill_alu_o), 64'(e[2*W]));
        check("z",   64'(z_alu_o),   64'(e[W-1:0] == '0));
        check("n",   64'(n_alu_o),   64'(e[W-1]));
      end
    end
  end

  initial begin
    int  w;
    int  lat;
    bit  rs;
    bit  saw;
    n_checks = 0;
    n_fail   = 0;
    rst_n       = 1'b0;
    valid_alu_i = 1'b0;
    ready_alu_i = 1'b1;
    op_alu_i    = '0;
    opr_a_alu_i = '0;
    opr_b_alu_i = '0;
    repeat (3) step();

    check("rst_ready", 64'(ready_alu_o), 64'd1);
    check("rst_valid", 64'(valid_alu_o), 64'd0);
    check("rst_res",   64'(res_alu_o),   64'd0);
    check("rst_hi",    64'(hi_alu_o),    64'd0);
    check("rst_ill",   64'(ill_alu_o),   64'd0);
    check("rst_z",     64'(z_alu_o),     64'd1);
    check("rst_n_flag",64'(n_alu_o),     64'd0);
    rst_n = 1'b1;
    step();

    // ADD overflow wraps; result valid right after the acceptance edge
    issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 1'b0, w);
    check("add_latency_valid", 64'(valid_alu_o), 64'd1);
    step();

    // back-to-back SUB then SLT
    issue(4'd1, 32'd5, 32'd5, 32'h0, 32'h0, 1'b0, w);
    issue(4'd9, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 1'b0, w);
    check("b2b_no_wait", 64'(w), 64'd0);
    check("b2b_valid", 64'(valid_alu_o), 64'd1);
    check("b2b_res", 64'(res_alu_o), 64'd1);

    // remaining single-cycle ops, issued back-to-back
    issue(4'd2, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32'h0, 1'b0, w);
    issue(4'd2, 32'h0000_0001, 32'h0000_0023, 32'h0000_0008, 32'h0, 1'b0, w);
    issue(4'd3, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 32'h0, 1'b0, w);
    issue(4'd5, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h0, 1'b0, w);
    issue(4'd6, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 32'h0, 1'b0, w);
    issue(4'd7, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, w);
    issue(4'd8, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 32'h0, 1'b0, w);
    issue(4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0, 1'b0, w);
    issue(4'd9, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, w);
    issue(4'd13, 32'h1234_5678, 32'h1, 32'h0, 32'h0, 1'b1, w);
    issue(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, w);
    step();

    // MULU full-range operands
    issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, w);
    wait_result(lat, rs);
    check("mulu_latency", 64'(lat), 64'(W+1));
    check("mulu_ready_low_busy", 64'(rs), 64'd0);
    issue(4'd11, 32'd3, 32'd5, 32'd15, 32'h0, 1'b0, w);
    wait_result(lat, rs);
    issue(4'd11, 32'h1234_5678, 32'h0000_0100, 32'h3456_7800, 32'h0000_0012, 1'b0, w);
    wait_result(lat, rs);
    step();

`ifdef SEQ_ALU_DIV_EN
    issue(4'd12, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, w);
    wait_result(lat, rs);
    check("divu_latency", 64'(lat), 64'(W+1));
    issue(4'd12, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b0, w);
    wait_result(lat, rs);
    step();
`else
    issue(4'd12, 32'd100, 32'd7, 32'h0, 32'h0, 1'b1, w);
    check("divu_ill_latency", 64'(valid_alu_o), 64'd1);
    step();
`endif
    step();

    // hold the result with ready_alu_i low; a competing request must wait
    ready_alu_i = 1'b0;
    issue(4'd4, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 32'h0, 1'b0, w);
    valid_alu_i = 1'b1;
    op_alu_i    = 4'd0;
    opr_a_alu_i = 32'd1;
    opr_b_alu_i = 32'd1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(valid_alu_o), 64'd1);
      check("hold_res", 64'(res_alu_o), 64'hF800_0000);
      check("hold_ready", 64'(ready_alu_o), 64'd0);
      step();
    end
    valid_alu_i = 1'b0;
    ready_alu_i = 1'b1;
    step();
    check("hold_release_idle", 64'(valid_alu_o), 64'd0);
    check("hold_queue_empty", 64'(exp_q.size()), 64'd0);

    // reset in the middle of a MULU
    issue(4'd11, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 32'h0000_0002, 1'b0, w);
    repeat (9) step();
    rst_n = 1'b0;
    exp_q.delete();
    step();
    check("midrst_valid", 64'(valid_alu_o), 64'd0);
    check("midrst_ready", 64'(ready_alu_o), 64'd1);
    check("midrst_z", 64'(z_alu_o), 64'd1);
    check("midrst_res", 64'(res_alu_o), 64'd0);
    rst_n = 1'b1;
    saw = 0;
    for (int i = 0; i < 45; i++) begin
      if (valid_alu_o !== 1'b0) saw = 1;
      step();
    end
    check("midrst_no_stale", 64'(saw), 64'd0);

    // a fresh op after the aborted one still works
    issue(4'd0, 32'd2, 32'd3, 32'd5, 32'h0, 1'b0, w);
    repeat (3) step();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
